irq_pending_latch_4ch: RTL

Upstream request-capture stage for the 4-to-2 priority encoder path. Latches rising edges on 4 request lines into sticky pending bits and applies a per-channel mask. Selects the highest-priority masked pending channel and offers its 2-bit id to a consumer over a valid/ready handshake. Clears the served pending bit on acceptance.

---
 rtl/irq_pending_latch_4ch.sv | 99 +++++++++
 1 files changed

// File: rtl/irq_pending_latch_4ch.sv
// Four-channel rising-edge request latch with masked priority offer over valid/ready.
// Optional coalesced-event counter enabled by defining IRQ_OVF_CNT_EN.
module irq_pending_latch_4ch #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_in,
  input  logic [3:0]       mask,
  output logic             out_valid,
  output logic [1:0]       out_id,
  input  logic             out_ready,
  output logic [3:0]       pending,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e     state_q, state_d;
  logic [1:0] id_q, id_d;
  logic [3:0] req_prev_q;
  logic [3:0] pending_q, pending_d;
  logic [3:0] ev, clr, sel;
  logic       handshake;

  assign ev        = req_in & ~req_prev_q;
  assign handshake = (state_q == StOffer) & out_ready;
  assign clr       = handshake ? (4'd1 << id_q) : 4'd0;
  // A fresh event wins over a same-cycle clear so it is never lost.
  assign pending_d = ev | (pending_q & ~clr);
  assign sel       = pending_q & mask;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      StIdle: begin
        if (|sel) begin
          state_d = StOffer;
          if (sel[3])      id_d = 2'd3;
          else if (sel[2]) id_d = 2'd2;
          else if (sel[1]) id_d = 2'd1;
          else             id_d = 2'd0;
        end
      end
      StOffer: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      id_q       <= 2'd0;
      req_prev_q <= 4'd0;
      pending_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      req_prev_q <= req_in;
      pending_q  <= pending_d;
    end
  end

  assign out_valid = (state_q == StOffer);
  assign out_id    = id_q;
  assign pending   = pending_q;

`ifdef IRQ_OVF_CNT_EN
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic             coalesced;

  assign coalesced = |(ev & pending_q & ~clr);

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = '0;
    end else if (coalesced && (ovf_q != {CNT_W{1'b1}})) begin
      ovf_d = ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end

  assign ovf_cnt = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_cnt        = '0;
`endif

endmodule
